pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 54 +++++
 tb/tb_pc_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with BOOT/RUN/HALT control, redirect, stall and advance counter.
// Optional macro PC_ALIGN_CHECK_EN rounds misaligned redirect targets down and flags them.
module pc_unit #(
  parameter int WIDTH = 32,
  parameter int STEP = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WIDTH-1:0]     redirect_target,
  input  logic                 halt,
  output logic [WIDTH-1:0]     pc_out,
  output logic [WIDTH-1:0]     pc_plus,
  output logic                 pc_valid,
  output logic [CNT_WIDTH-1:0] adv_count,
  output logic                 misalign
);
  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;
  logic [1:0] state, state_n;
  logic [WIDTH-1:0] pc_n, target;
  logic load, upd;
  assign pc_plus = pc_out + WIDTH'(STEP);
  assign pc_valid = state == RUN;
`ifdef PC_ALIGN_CHECK_EN
  assign target = redirect_target & ~WIDTH'(STEP - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) misalign <= 1'b0;
    else if (load && (redirect_target & WIDTH'(STEP - 1)) != '0) misalign <= 1'b1;
`else
  assign target = redirect_target;
  assign misalign = 1'b0;
`endif
  always_comb begin
    load = state != BOOT && redirect;
    state_n = (state == BOOT || load) ? RUN : halt ? HALT : RUN;
    pc_n = load ? target : (state == RUN && !halt && !stall) ? pc_plus : pc_out;
    upd = load || pc_n != pc_out;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= BOOT;
      pc_out <= RESET_VECTOR;
      adv_count <= '0;
    end else begin
      state <= state_n;
      pc_out <= pc_n;
      if (upd) adv_count <= adv_count + CNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit (32-bit default instance plus an 8-bit/4-bit-counter instance).
module tb_pc_unit;
  logic clk = 0, reset = 0, stall = 0, redirect = 0, halt = 0;
  logic [31:0] redirect_target = '0;
  logic [31:0] pc_out, pc_plus;
  logic pc_valid, misalign;
  logic [15:0] adv_count;
  logic reset8 = 0, stall8 = 0, redirect8 = 0, halt8 = 0;
  logic [7:0] target8 = '0, pc8, plus8;
  logic valid8, mis8;
  logic [3:0] cnt8;
  int checks = 0, failures = 0;
  int exp_cnt;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .halt(halt), .pc_out(pc_out),
    .pc_plus(pc_plus), .pc_valid(pc_valid), .adv_count(adv_count), .misalign(misalign)
  );

  pc_unit #(.WIDTH(8), .STEP(4), .RESET_VECTOR(8'h00), .CNT_WIDTH(4)) dut8 (
    .clk(clk), .reset(reset8), .stall(stall8), .redirect(redirect8),
    .redirect_target(target8), .halt(halt8), .pc_out(pc8),
    .pc_plus(plus8), .pc_valid(valid8), .adv_count(cnt8), .misalign(mis8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #6;
    checks++;
    if (pc_out !== 32'h0 || pc_valid !== 1'b0 || adv_count !== 16'd0 || misalign !== 1'b0) begin
      failures++;
      $display("FAIL reset_state pc=%h valid=%b cnt=%0d mis=%b want pc=0 valid=0 cnt=0 mis=0", pc_out, pc_valid, adv_count, misalign);
    end
    #1 reset = 1;
    #3;
    checks++;
    if (pc_out !== 32'h0 || pc_valid !== 1'b0) begin
      failures++;
      $display("FAIL boot_cycle pc=%h valid=%b want pc=0 valid=0", pc_out, pc_valid);
    end
    step();
    checks++;
    if (pc_out !== 32'h0 || pc_valid !== 1'b1 || pc_plus !== 32'h4) begin
      failures++;
      $display("FAIL first_run pc=%h valid=%b plus=%h want 0/1/4", pc_out, pc_valid, pc_plus);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (pc_out !== 32'(4 * i) || adv_count !== 16'(i)) begin
        failures++;
        $display("FAIL seq_advance pc=%h cnt=%0d want pc=%h cnt=%0d", pc_out, adv_count, 32'(4 * i), i);
      end
    end
    exp_cnt = 3;
  endtask

  task automatic test_stall();
    redirect = 1; redirect_target = 32'h10;
    step();
    redirect = 0; stall = 1;
    exp_cnt++;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (pc_out !== 32'h10 || adv_count !== 16'(exp_cnt)) begin
        failures++;
        $display("FAIL stall_hold pc=%h cnt=%0d want pc=10 cnt=%0d", pc_out, adv_count, exp_cnt);
      end
    end
    redirect = 1; redirect_target = 32'h100;
    step();
    exp_cnt++;
    redirect = 0; stall = 0;
    checks++;
    if (pc_out !== 32'h100 || adv_count !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL redirect_over_stall pc=%h cnt=%0d want pc=100 cnt=%0d", pc_out, adv_count, exp_cnt);
    end
  endtask

  task automatic test_halt();
    redirect = 1; redirect_target = 32'h20;
    step();
    exp_cnt++;
    redirect = 0; halt = 1;
    step();
    stall = 1;
    step();
    checks++;
    if (pc_out !== 32'h20 || pc_valid !== 1'b0 || adv_count !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL halt_hold pc=%h valid=%b cnt=%0d want pc=20 valid=0 cnt=%0d", pc_out, pc_valid, adv_count, exp_cnt);
    end
    halt = 0; stall = 0;
    step();
    checks++;
    if (pc_out !== 32'h20 || pc_valid !== 1'b1) begin
      failures++;
      $display("FAIL halt_exit pc=%h valid=%b want pc=20 valid=1", pc_out, pc_valid);
    end
    step();
    exp_cnt++;
    checks++;
    if (pc_out !== 32'h24 || adv_count !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL after_halt pc=%h cnt=%0d want pc=24 cnt=%0d", pc_out, adv_count, exp_cnt);
    end
    halt = 1;
    step();
    redirect = 1; redirect_target = 32'h40;
    step();
    exp_cnt++;
    checks++;
    if (pc_out !== 32'h40 || pc_valid !== 1'b1 || adv_count !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL halt_redirect pc=%h valid=%b cnt=%0d want pc=40 valid=1 cnt=%0d", pc_out, pc_valid, adv_count, exp_cnt);
    end
    redirect_target = 32'h50;
    step();
    exp_cnt++;
    redirect = 0; halt = 0;
    step();
    exp_cnt++;
    checks++;
    if (pc_out !== 32'h54 || pc_valid !== 1'b1 || adv_count !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL run_redirect_halt pc=%h valid=%b cnt=%0d want pc=54 valid=1 cnt=%0d", pc_out, pc_valid, adv_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    redirect = 1; redirect_target = 32'h54;
    step();
    exp_cnt++;
    redirect = 0;
    checks++;
    if (pc_out !== 32'h54 || adv_count !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL redirect_same pc=%h cnt=%0d want pc=54 cnt=%0d", pc_out, adv_count, exp_cnt);
    end
  endtask

  task automatic test_align();
    logic exp_mis;
`ifdef PC_ALIGN_CHECK_EN
    exp_pc = 32'h100; exp_mis = 1'b1;
`else
    exp_pc = 32'h102; exp_mis = 1'b0;
`endif
    redirect = 1; redirect_target = 32'h102;
    step();
    redirect = 0;
    checks++;
    if (pc_out !== exp_pc || misalign !== exp_mis) begin
      failures++;
      $display("FAIL align_load pc=%h mis=%b want pc=%h mis=%b", pc_out, misalign, exp_pc, exp_mis);
    end
    step();
    checks++;
    if (pc_out !== exp_pc + 32'h4 || misalign !== exp_mis) begin
      failures++;
      $display("FAIL align_sticky pc=%h mis=%b want pc=%h mis=%b", pc_out, misalign, exp_pc + 32'h4, exp_mis);
    end
  endtask

  task automatic test_mid_reset();
    redirect = 1; redirect_target = 32'h30;
    step();
    redirect_target = 32'h80; halt = 1;
    #3 reset = 0;
    #1;
    checks++;
    if (pc_out !== 32'h0 || adv_count !== 16'd0 || pc_valid !== 1'b0 || misalign !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset pc=%h cnt=%0d valid=%b mis=%b want 0/0/0/0", pc_out, adv_count, pc_valid, misalign);
    end
    redirect = 0; halt = 0;
    step();
    reset = 1;
    step();
    step();
    checks++;
    if (pc_out !== 32'h4 || pc_valid !== 1'b1 || adv_count !== 16'd1) begin
      failures++;
      $display("FAIL post_reset pc=%h valid=%b cnt=%0d want pc=4 valid=1 cnt=1", pc_out, pc_valid, adv_count);
    end
  endtask

  task automatic test_wrap();
    #2 reset8 = 1;
    step();
    redirect8 = 1; target8 = 8'hF8;
    step();
    redirect8 = 0;
    step();
    checks++;
    if (pc8 !== 8'hFC || plus8 !== 8'h00 || cnt8 !== 4'd2) begin
      failures++;
      $display("FAIL wrap_fc pc=%h plus=%h cnt=%0d want fc/00/2", pc8, plus8, cnt8);
    end
    step();
    checks++;
    if (pc8 !== 8'h00 || plus8 !== 8'h04 || cnt8 !== 4'd3 || valid8 !== 1'b1) begin
      failures++;
      $display("FAIL wrap_00 pc=%h plus=%h cnt=%0d valid=%b want 00/04/3/1", pc8, plus8, cnt8, valid8);
    end
    repeat (12) step();
    checks++;
    if (pc8 !== 8'h30 || cnt8 !== 4'd15) begin
      failures++;
      $display("FAIL cnt_full pc=%h cnt=%0d want pc=30 cnt=15", pc8, cnt8);
    end
    step();
    checks++;
    if (pc8 !== 8'h34 || cnt8 !== 4'd0) begin
      failures++;
      $display("FAIL cnt_wrap pc=%h cnt=%0d want pc=34 cnt=0", pc8, cnt8);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_halt();
    test_back_to_back();
    test_align();
    test_mid_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
